// File: rtl/frame_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// frame_tx_scheduler_if
//   Control/status bundle between the link-test control registers (master)
//   and the frame scheduler (slave).
//   master drives : start, stop, num_frames, gap_cycles
//   slave drives  : send_enable, busy, frame_start, frame_end, frames_sent, done
// -----------------------------------------------------------------------------
interface frame_tx_scheduler_if #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 8
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] num_frames;
  logic [GAP_W-1:0] gap_cycles;
  logic             send_enable;
  logic             busy;
  logic             frame_start;
  logic             frame_end;
  logic [CNT_W-1:0] frames_sent;
  logic             done;

  modport master (
    output start, stop, num_frames, gap_cycles,
    input  send_enable, busy, frame_start, frame_end, frames_sent, done
  );

  modport slave (
    input  start, stop, num_frames, gap_cycles,
    output send_enable, busy, frame_start, frame_end, frames_sent, done
  );
endinterface

// File: rtl/frame_tx_scheduler.sv
// -----------------------------------------------------------------------------
// frame_tx_scheduler
//   Sequences the PRBS frame generator (HEAD, PRBS_LENGTH payload, TAIL) for
//   link tests: a programmed number of frames or a continuous run, with a
//   programmable idle gap between frames. Frame alignment is derived purely
//   from an L-cycle counter (L = PRBS_LENGTH+2); the generator is not read back.
// Ports
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : slave side of frame_tx_scheduler_if
//          start/stop/num_frames/gap_cycles in,
//          send_enable/busy/frame_start/frame_end/frames_sent/done out
// -----------------------------------------------------------------------------
module frame_tx_scheduler #(
  parameter int PRBS_LENGTH = 8,
  parameter int CNT_W       = 16,
  parameter int GAP_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  frame_tx_scheduler_if.slave   bus
);

  localparam int L     = PRBS_LENGTH + 2;
  localparam int IDX_W = $clog2(L);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_FRAME,
    S_GAP
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [CNT_W-1:0]   r_num_frames;
  logic [GAP_W-1:0]   r_gap_cycles;
  logic [CNT_W-1:0]   r_frames_sent;
  logic               r_stop_pending;
  logic               r_done;

  state_t             w_next_state;
  logic               w_send_enable;
  logic               w_is_tail;
  logic               w_last;
  logic [CNT_W-1:0]   w_frames_inc;

  assign w_is_tail    = (r_state == S_FRAME) && (r_idx == IDX_W'(L - 1));
  assign w_frames_inc = r_frames_sent + 1'b1;
  // Final frame of the run: counted target reached, or a stop already latched.
  assign w_last       = ((r_num_frames != '0) && (w_frames_inc == r_num_frames))
                        || r_stop_pending;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_next_state  = r_state;
    w_send_enable = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_next_state = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_send_enable = 1'b1;
        w_next_state  = S_FRAME;
      end
      S_FRAME: begin
        if (w_is_tail) begin
          if (w_last) begin
            w_next_state = S_IDLE;
          end else if (r_gap_cycles == '0) begin
            // Back-to-back: request the next frame during this TAIL cycle.
            w_send_enable = 1'b1;
            w_next_state  = S_FRAME;
          end else if (r_gap_cycles == GAP_W'(1)) begin
            w_next_state = S_LAUNCH;
          end else begin
            w_next_state = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (r_stop_pending)       w_next_state = S_IDLE;
        else if (r_gap_cnt == '0) w_next_state = S_LAUNCH;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_gap_cnt      <= '0;
      r_num_frames   <= '0;
      r_gap_cycles   <= '0;
      r_frames_sent  <= '0;
      r_stop_pending <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values of the others; later assignments in this
      // block (e.g. start clearing stop_pending) override earlier ones.
      r_state <= w_next_state;
      r_done  <= 1'b0;
      if (bus.stop) r_stop_pending <= 1'b1;

      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_num_frames   <= bus.num_frames;
            r_gap_cycles   <= bus.gap_cycles;
            r_frames_sent  <= '0;
            r_stop_pending <= 1'b0;
          end
        end
        S_LAUNCH: begin
          r_idx <= '0;
        end
        S_FRAME: begin
          if (w_is_tail) begin
            r_idx         <= '0;
            r_frames_sent <= w_frames_inc;
            r_done        <= w_last;
            // GAP lasts gap-1 cycles and LAUNCH is the last idle cycle, so the
            // counter starts at gap-2; only meaningful when gap >= 2.
            r_gap_cnt     <= r_gap_cycles - GAP_W'(2);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_GAP: begin
          if (r_stop_pending)      r_done    <= 1'b1;
          else if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.send_enable = w_send_enable;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.frame_start = (r_state == S_FRAME) && (r_idx == '0);
  assign bus.frame_end   = w_is_tail;
  assign bus.frames_sent = r_frames_sent;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_tx_scheduler
//   Directed bench for frame_tx_scheduler (PRBS_LENGTH=8, L=10). Each run holds
//   start in cycle t0 and records per-cycle output traces as bit vectors
//   (bit t = value in cycle t), which are compared with hand-derived masks.
// -----------------------------------------------------------------------------
module tb_frame_tx_scheduler;

  localparam int CNT_W = 16;
  localparam int GAP_W = 8;

  logic clk;
  logic rst;

  frame_tx_scheduler_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  frame_tx_scheduler #(
    .PRBS_LENGTH (8),
    .CNT_W       (CNT_W),
    .GAP_W       (GAP_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  logic [63:0] tr_se, tr_fs, tr_fe, tr_busy, tr_done;
  logic [CNT_W-1:0] end_frames;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] at(input int t);
    logic [63:0] one;
    one = 64'd1;
    return one << t;
  endfunction

  function automatic logic [63:0] span(input int a, input int b);
    logic [63:0] m;
    m = '0;
    for (int i = a; i <= b; i++) m |= at(i);
    return m;
  endfunction

  // Runs n cycles starting at t0 (we are just after a posedge). Inputs change
  // 1 time unit after a posedge; outputs are sampled on the negedge.
  // A negative *_at argument means that event does not happen.
  task automatic run(input int num, input int gap, input int stop_at,
                     input int rst_at, input int restart_at, input int chg_at,
                     input int n);
    tr_se = '0; tr_fs = '0; tr_fe = '0; tr_busy = '0; tr_done = '0;
    bus.num_frames = CNT_W'(num);
    bus.gap_cycles = GAP_W'(gap);
    for (int t = 0; t < n; t++) begin
      bus.start = (t == 0) || (t == restart_at);
      bus.stop  = (t == stop_at);
      rst       = (t == rst_at);
      if (t == chg_at) begin
        bus.num_frames = '0;
        bus.gap_cycles = GAP_W'(7);
      end
      @(negedge clk);
      tr_se[t]   = bus.send_enable;
      tr_fs[t]   = bus.frame_start;
      tr_fe[t]   = bus.frame_end;
      tr_busy[t] = bus.busy;
      tr_done[t] = bus.done;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    rst       = 1'b0;
    end_frames = bus.frames_sent;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.num_frames = '0;
    bus.gap_cycles = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst send_enable", 64'(bus.send_enable), 64'd0);
    check("rst busy",        64'(bus.busy),        64'd0);
    check("rst frame_start", 64'(bus.frame_start), 64'd0);
    check("rst frame_end",   64'(bus.frame_end),   64'd0);
    check("rst frames_sent", 64'(bus.frames_sent), 64'd0);
    check("rst done",        64'(bus.done),        64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // T1: single frame, HEAD t2, TAIL t11, done t12.
    run(1, 0, -1, -1, -1, -1, 16);
    check("T1 send_enable", tr_se,   at(1));
    check("T1 frame_start", tr_fs,   at(2));
    check("T1 frame_end",   tr_fe,   at(11));
    check("T1 busy",        tr_busy, span(1, 11));
    check("T1 done",        tr_done, at(12));
    check("T1 frames_sent", 64'(end_frames), 64'd1);

    // T2: three back-to-back frames; next launch rides on each TAIL cycle.
    run(3, 0, -1, -1, -1, -1, 36);
    check("T2 send_enable", tr_se,   at(1) | at(11) | at(21));
    check("T2 frame_start", tr_fs,   at(2) | at(12) | at(22));
    check("T2 frame_end",   tr_fe,   at(11) | at(21) | at(31));
    check("T2 busy",        tr_busy, span(1, 31));
    check("T2 done",        tr_done, at(32));
    check("T2 frames_sent", 64'(end_frames), 64'd3);

    // T3: gap=3 -> generator idle t12..t14, launch t14, HEAD t15.
    // Config is changed at t3 and must be ignored.
    run(2, 3, -1, -1, -1, 3, 30);
    check("T3 send_enable", tr_se,   at(1) | at(14));
    check("T3 frame_start", tr_fs,   at(2) | at(15));
    check("T3 frame_end",   tr_fe,   at(11) | at(24));
    check("T3 busy",        tr_busy, span(1, 24));
    check("T3 done",        tr_done, at(25));
    check("T3 frames_sent", 64'(end_frames), 64'd2);

    // gap=1: launch directly in the cycle after TAIL.
    run(2, 1, -1, -1, -1, -1, 28);
    check("G1 send_enable", tr_se,   at(1) | at(12));
    check("G1 frame_start", tr_fs,   at(2) | at(13));
    check("G1 done",        tr_done, at(23));

    // T4a: continuous, gap=5 (GAP t12..t15). stop at t13 -> pending t14,
    // GAP abort decided t14 -> done t15, no second launch.
    run(0, 5, 13, -1, -1, -1, 24);
    check("T4a send_enable", tr_se,   at(1));
    check("T4a busy",        tr_busy, span(1, 14));
    check("T4a done",        tr_done, at(15));
    check("T4a frames_sent", 64'(end_frames), 64'd1);

    // T4b: continuous, gap=2; stop at t18 during frame 2 (HEAD t14, TAIL t23).
    run(0, 2, 18, -1, -1, -1, 30);
    check("T4b send_enable", tr_se,   at(1) | at(13));
    check("T4b frame_end",   tr_fe,   at(11) | at(23));
    check("T4b done",        tr_done, at(24));
    check("T4b frames_sent", 64'(end_frames), 64'd2);

    // T6: counted single frame, stop in the decision cycle: ends anyway.
    run(1, 0, 11, -1, -1, -1, 16);
    check("T6 send_enable", tr_se,   at(1));
    check("T6 done",        tr_done, at(12));
    check("T6 frames_sent", 64'(end_frames), 64'd1);

    // Continuous, stop in the decision cycle: one more frame is launched.
    run(0, 0, 11, -1, -1, -1, 26);
    check("C6 send_enable", tr_se,   at(1) | at(11));
    check("C6 frame_end",   tr_fe,   at(11) | at(21));
    check("C6 done",        tr_done, at(22));
    check("C6 frames_sent", 64'(end_frames), 64'd2);

    // start and stop together in IDLE: stop ignored, both frames sent.
    run(2, 0, 0, -1, -1, -1, 26);
    check("SS send_enable", tr_se,   at(1) | at(11));
    check("SS done",        tr_done, at(22));
    check("SS frames_sent", 64'(end_frames), 64'd2);

    // T5: start again at t5 (ignored), rst at t6 -> everything 0 from t7.
    run(3, 0, -1, 6, 5, -1, 20);
    check("T5 send_enable", tr_se,   at(1));
    check("T5 frame_start", tr_fs,   at(2));
    check("T5 frame_end",   tr_fe,   64'd0);
    check("T5 busy",        tr_busy, span(1, 6));
    check("T5 done",        tr_done, 64'd0);
    check("T5 frames_sent", 64'(end_frames), 64'd0);

    // A fresh run after the reset behaves like T1.
    run(1, 0, -1, -1, -1, -1, 16);
    check("T5b frame_start", tr_fs,   at(2));
    check("T5b frame_end",   tr_fe,   at(11));
    check("T5b done",        tr_done, at(12));
    check("T5b frames_sent", 64'(end_frames), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
